// File: rtl/branch_resolver_if.sv
// Bundle of fetch-side prediction, EX-stage operands and resolved branch outcome.
// The pipeline/predictor side drives it through master; the resolver uses slave.
interface branch_resolver_if #(
  parameter int CNT_W = 32
);
  logic              memory_stall;
  logic              flush;
  logic [31:0]       pc_1;
  logic              pred_taken_1;
  logic [31:0]       pred_target_1;
  logic              is_branch_ex;
  logic              is_jal_ex;
  logic              is_jalr_ex;
  logic [2:0]        funct3_ex;
  logic [31:0]       rs1_ex;
  logic [31:0]       rs2_ex;
  logic [31:0]       imm_ex;
  logic [31:0]       instructionPC_3;
  logic              is_branchInst_3;
  logic              taken_3;
  logic              prev_taken_3;
  logic [31:0]       target_3;
  logic              mispredict_3;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispredict_cnt;

  modport master (
    output memory_stall, flush, pc_1, pred_taken_1, pred_target_1,
           is_branch_ex, is_jal_ex, is_jalr_ex, funct3_ex, rs1_ex, rs2_ex, imm_ex,
    input  instructionPC_3, is_branchInst_3, taken_3, prev_taken_3, target_3,
           mispredict_3, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  memory_stall, flush, pc_1, pred_taken_1, pred_target_1,
           is_branch_ex, is_jal_ex, is_jalr_ex, funct3_ex, rs1_ex, rs2_ex, imm_ex,
    output instructionPC_3, is_branchInst_3, taken_3, prev_taken_3, target_3,
           mispredict_3, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolver.sv
// Carries fetch-time predictions IF->ID->EX, resolves branches/jumps in EX and reports outcome plus perf counters.
// Latency: prediction visible at EX two unstalled cycles after fetch; EX outputs are combinational from S3 and EX inputs.
// Backpressure: memory_stall freezes both stages and counters; flush squashes ID/EX valids unless stalled.
module branch_resolver #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_resolver_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s2_vld;
  logic [31:0]      s2_pc;
  logic             s2_pred_taken;
  logic [31:0]      s2_pred_target;
  logic             s3_vld;
  logic [31:0]      s3_pc;
  logic             s3_pred_taken;
  logic [31:0]      s3_pred_target;

  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispredict_cnt_q;

  logic             cond_taken;
  logic             v3;
  logic             taken;
  logic             prev_taken;
  logic             mispredict;
  logic [31:0]      pc_plus_imm;
  logic [31:0]      jalr_sum;
  logic [31:0]      target;

  // Advance the prediction through ID and EX; flush kills the wrong-path slots, stall freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld         <= 1'b0;
      s2_pc          <= 32'h0;
      s2_pred_taken  <= 1'b0;
      s2_pred_target <= 32'h0;
      s3_vld         <= 1'b0;
      s3_pc          <= 32'h0;
      s3_pred_taken  <= 1'b0;
      s3_pred_target <= 32'h0;
    end else if (!bus.memory_stall) begin
      s2_vld         <= ~bus.flush;
      s2_pc          <= bus.pc_1;
      s2_pred_taken  <= bus.pred_taken_1;
      s2_pred_target <= bus.pred_target_1;
      s3_vld         <= s2_vld & ~bus.flush;
      s3_pc          <= s2_pc;
      s3_pred_taken  <= s2_pred_taken;
      s3_pred_target <= s2_pred_target;
    end
  end

  // Evaluate the conditional-branch comparison selected by funct3; reserved encodings fall through.
  always_comb begin
    cond_taken = 1'b0;
    case (bus.funct3_ex)
      3'b000:  cond_taken = (bus.rs1_ex == bus.rs2_ex);
      3'b001:  cond_taken = (bus.rs1_ex != bus.rs2_ex);
      3'b100:  cond_taken = ($signed(bus.rs1_ex) <  $signed(bus.rs2_ex));
      3'b101:  cond_taken = ($signed(bus.rs1_ex) >= $signed(bus.rs2_ex));
      3'b110:  cond_taken = (bus.rs1_ex <  bus.rs2_ex);
      3'b111:  cond_taken = (bus.rs1_ex >= bus.rs2_ex);
      default: cond_taken = 1'b0;
    endcase
  end

  assign v3          = s3_vld & (bus.is_branch_ex | bus.is_jal_ex | bus.is_jalr_ex);
  assign taken       = v3 & (bus.is_jal_ex | bus.is_jalr_ex | (bus.is_branch_ex & cond_taken));
  assign prev_taken  = s3_vld & s3_pred_taken;
  assign pc_plus_imm = s3_pc + bus.imm_ex;
  assign jalr_sum    = bus.rs1_ex + bus.imm_ex;

  // Pick the real next PC; gated by v3 so an empty EX slot always points at pc+4.
  always_comb begin
    target = s3_pc + 32'd4;
    if (v3 && bus.is_jalr_ex) begin
      target = {jalr_sum[31:1], 1'b0};
    end else if (taken) begin
      target = pc_plus_imm;
    end
  end

  // A target mismatch only matters when both prediction and outcome say taken.
  assign mispredict = v3 & ((taken != prev_taken) |
                            (taken & prev_taken & (s3_pred_target != target)));

  // Saturating branch and mispredict counters, updated on every unstalled edge (flush included).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (!bus.memory_stall) begin
      if (v3 && (branch_cnt_q != CNT_MAX)) begin
        branch_cnt_q <= branch_cnt_q + CNT_ONE;
      end
      if (mispredict && (mispredict_cnt_q != CNT_MAX)) begin
        mispredict_cnt_q <= mispredict_cnt_q + CNT_ONE;
      end
    end
  end

  assign bus.instructionPC_3 = s3_pc;
  assign bus.is_branchInst_3 = v3;
  assign bus.taken_3         = taken;
  assign bus.prev_taken_3    = prev_taken;
  assign bus.target_3        = target;
  assign bus.mispredict_3    = mispredict;
  assign bus.branch_cnt      = branch_cnt_q;
  assign bus.mispredict_cnt  = mispredict_cnt_q;

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolves branches and jumps in EX (stage 3) and returns the outcome to the fetch-stage predictor. It carries each fetch-time prediction (taken flag and predicted target) through IF→ID→EX alongside the instruction, evaluates the real condition and target, and drives the predictor's update/redirect inputs. It also keeps saturating branch and mispredict counters for performance analysis.

## Interface
Parameters:
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- memory_stall  in  1  freezes all internal pipeline registers and counters
- flush  in  1  redirect from predictor; squashes the wrong-path instructions in IF and ID
- pc_1  in  32  PC of the instruction in IF
- pred_taken_1  in  1  predictor's taken decision for pc_1
- pred_target_1  in  32  predictor's next PC for pc_1
- is_branch_ex  in  1  EX instruction is a B-type conditional branch
- is_jal_ex  in  1  EX instruction is JAL
- is_jalr_ex  in  1  EX instruction is JALR
- funct3_ex  in  3  branch condition field
- rs1_ex, rs2_ex  in  32  forwarded operand values
- imm_ex  in  32  sign-extended immediate
- instructionPC_3  out  32  PC of the EX instruction
- is_branchInst_3  out  1  valid EX instruction is a branch or jump
- taken_3  out  1  resolved direction
- prev_taken_3  out  1  direction predicted at fetch
- target_3  out  32  resolved correct next PC
- mispredict_3  out  1  direction or target was wrong
- branch_cnt  out  CNT_W  resolved branches and jumps
- mispredict_cnt  out  CNT_W  mispredictions

## Operation
- Two register stages, S2 (ID) and S3 (EX). Each holds valid, pc, pred_taken, and pred_target.
- When memory_stall=0, each clock edge does S1→S2 and S2→S3. S2.valid is loaded with 1 and S3.valid with S2.valid.
- When memory_stall=1, all stage registers and counters hold.
- When flush=1 and memory_stall=0: S2.valid and S3.valid load 0. Both counters still update for the EX instruction resolved in that cycle.
- When flush=1 and memory_stall=1: no stage register changes; stall has priority.
- Conditional branch direction, decoded from funct3_ex:
  - 000 BEQ; 001 BNE; 100 BLT signed; 101 BGE signed; 110 BLTU; 111 BGEU.
  - 010 and 011 resolve as not taken.
- JAL and JALR always resolve as taken.
- target_3, all adds modulo 2^32:
  - taken branch or JAL: pc_3 + imm_ex
  - JALR: (rs1_ex + imm_ex) with bit 0 cleared
  - not taken: pc_3 + 4
- v3 = S3.valid & (is_branch_ex | is_jal_ex | is_jalr_ex).
- is_branchInst_3 = v3.
- prev_taken_3 = S3.valid & S3.pred_taken.
- taken_3 = v3 & resolved direction.
- instructionPC_3 = S3.pc.
- mispredict_3 = v3 & ((taken_3 != prev_taken_3) | (taken_3 & prev_taken_3 & S3.pred_target != target_3)).
- A non-branch instruction never mispredicts, even if S3.pred_taken=1.
- Counters, when memory_stall=0:
  - branch_cnt += v3
  - mispredict_cnt += mispredict_3
  - Both saturate at 2^CNT_W-1.

## Timing
- Asynchronous reset clears every stage register, both valids, and both counters to 0.
- Output values during and after reset: all outputs 0 except instructionPC_3 = 0 and target_3 = 4.
- A prediction presented in cycle N appears on prev_taken_3 in cycle N+2 when there are no stalls. Each stall cycle adds one cycle.
- All stage-3 outputs are combinational from the S3 registers and the EX inputs. The predictor samples them in the same cycle.
- Counters reflect an event on the edge that ends the resolving cycle.
- Reset mid-operation discards in-flight predictions; the first two cycles after reset have S3.valid=0.

## Test plan
- Correct-taken BEQ:
  - Stimulus: pc_1=0x100, pred_taken_1=1, pred_target_1=0x120; two cycles later is_branch_ex=1, funct3=000, rs1=rs2=5, imm=0x20.
  - Required: taken_3=1, prev_taken_3=1, target_3=0x120, mispredict_3=0; branch_cnt=1, mispredict_cnt=0.
- Direction mispredict:
  - Stimulus: BLT with rs1=0xFFFFFFFF, rs2=1, pc=0x200, pred_taken=0.
  - Required: taken_3=1, target_3=0x200+imm, mispredict_3=1, mispredict_cnt increments.
  - Repeat as BLTU with the same operands: not taken, no mispredict.
- Target mispredict:
  - Stimulus: JALR at pc 0x300, rs1=0x1001, imm=4, pred_target=0x2000.
  - Required: target_3=0x1004, mispredict_3=1.
- Flush squash:
  - Stimulus: flush=1 for one cycle with valid S2 and S3 holding predicted-taken entries.
  - Required: the next two cycles show is_branchInst_3=0 and prev_taken_3=0 regardless of the ex inputs; counters are unchanged by the squashed slots.
- Stall hold:
  - Stimulus: memory_stall=1 for 3 cycles while S3 holds a mispredicted branch.
  - Required: outputs are stable, counters increment only once (after the stall releases), and a flush asserted during the stall is ignored.
- Reset and saturation:
  - Stimulus: assert rst_n=0 asynchronously mid-stream; then, with CNT_W=2, resolve 5 branches.
  - Required: reset gives all-zero outputs (target_3=4) immediately; branch_cnt then holds at 3.
